// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode-and-issue stage: opcode map, ALU and branch
// encodings, the registered control bundle and the issue FSM states.
package ctrl_pkg;

    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 3;
    localparam int unsigned OP_AND  = 5;
    localparam int unsigned OP_OR   = 6;
    localparam int unsigned OP_NOR  = 7;
    localparam int unsigned OP_XOR  = 8;
    localparam int unsigned OP_SLA  = 9;
    localparam int unsigned OP_SLL  = 10;
    localparam int unsigned OP_SRA  = 11;
    localparam int unsigned OP_SRL  = 12;
    localparam int unsigned OP_MUL  = 14;
    localparam int unsigned OP_ADDI = 32;
    localparam int unsigned OP_SUBI = 33;
    localparam int unsigned OP_LD   = 36;
    localparam int unsigned OP_ST   = 37;
    localparam int unsigned OP_BEZ  = 40;
    localparam int unsigned OP_BNE  = 41;
    localparam int unsigned OP_JMP  = 42;

    // Native 4-bit ALU encodings; SLA and SLL share a shifter operation.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLA = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_MUL = 4'b1011;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    typedef struct packed {
        logic [3:0] alu_command;
        logic       mem_read;
        logic       mem_write;
        logic       wb_enable;
        logic       is_immediate;
        logic [1:0] branch;
    } ctrl_bundle_t;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_BUSY
    } ctrl_state_e;

    function automatic ctrl_bundle_t alu_bundle(input logic [3:0] cmd, input logic imm);
        ctrl_bundle_t b;
        b              = '0;
        b.alu_command  = cmd;
        b.wb_enable    = 1'b1;
        b.is_immediate = imm;
        return b;
    endfunction

    localparam ctrl_bundle_t MUL_BUNDLE = '{alu_command: ALU_MUL, mem_read: 1'b0,
                                            mem_write: 1'b0, wb_enable: 1'b1,
                                            is_immediate: 1'b0, branch: BR_NONE};

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational opcode decoder: control bundle plus MUL and undefined-opcode flags.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
)
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_bundle_t        bundle_o,
    output logic                is_mul_o,
    output logic                is_illegal_o
);

    logic [31:0] op_wide;

    assign op_wide = 32'(opcode_i);

    always_comb begin
        bundle_o     = '0;
        is_mul_o     = 1'b0;
        is_illegal_o = 1'b0;
        case (op_wide)
            OP_NOP:  bundle_o = '0;
            OP_ADD:  bundle_o = alu_bundle(ALU_ADD, 1'b0);
            OP_SUB:  bundle_o = alu_bundle(ALU_SUB, 1'b0);
            OP_AND:  bundle_o = alu_bundle(ALU_AND, 1'b0);
            OP_OR:   bundle_o = alu_bundle(ALU_OR,  1'b0);
            OP_NOR:  bundle_o = alu_bundle(ALU_NOR, 1'b0);
            OP_XOR:  bundle_o = alu_bundle(ALU_XOR, 1'b0);
            OP_SLA:  bundle_o = alu_bundle(ALU_SLA, 1'b0);
            OP_SLL:  bundle_o = alu_bundle(ALU_SLL, 1'b0);
            OP_SRA:  bundle_o = alu_bundle(ALU_SRA, 1'b0);
            OP_SRL:  bundle_o = alu_bundle(ALU_SRL, 1'b0);
            OP_MUL: begin
                bundle_o = MUL_BUNDLE;
                is_mul_o = 1'b1;
            end
            OP_ADDI: bundle_o = alu_bundle(ALU_ADD, 1'b1);
            OP_SUBI: bundle_o = alu_bundle(ALU_SUB, 1'b1);
            OP_LD: begin
                bundle_o          = alu_bundle(ALU_ADD, 1'b1);
                bundle_o.mem_read = 1'b1;
            end
            OP_ST: begin
                bundle_o.mem_write    = 1'b1;
                bundle_o.is_immediate = 1'b1;
            end
            OP_BEZ: begin
                bundle_o.is_immediate = 1'b1;
                bundle_o.branch       = BR_BEZ;
            end
            OP_BNE: begin
                bundle_o.is_immediate = 1'b1;
                bundle_o.branch       = BR_BNE;
            end
            OP_JMP: begin
                bundle_o.is_immediate = 1'b1;
                bundle_o.branch       = BR_JMP;
            end
            default: is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered decode-and-issue stage with stall/flush handling and a multi-cycle MUL
// sequencer. Optional undefined-opcode trap is enabled by defining CTRL_ILLEGAL_TRAP_EN.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int ALU_CMD_W  = 4,
    parameter int MUL_CYCLES = 4
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 freeze,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [ALU_CMD_W-1:0] alu_command,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 wb_enable,
    output logic                 is_immediate,
    output logic [1:0]           branch,
    output logic                 stall_o,
    output logic                 illegal_o,
    output logic                 illegal_seen
);

    localparam int              CNT_W    = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_bundle_t     bundle_q, bundle_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;
    logic             seen_q, seen_d;

    ctrl_bundle_t dec_bundle;
    logic         dec_is_mul;
    logic         dec_is_illegal;
    logic         is_nop;

    ctrl_decode_comb #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode_i     (opcode),
        .bundle_o     (dec_bundle),
        .is_mul_o     (dec_is_mul),
        .is_illegal_o (dec_is_illegal)
    );

    assign is_nop = (32'(opcode) == OP_NOP);

    // Any non-frozen cycle starts from a bubble; the counter reaching zero is the
    // same edge that issues the MUL, so stall covers MUL_CYCLES-1 cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bundle_d  = bundle_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        seen_d    = seen_q;
        if (flush) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            bundle_d  = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (!freeze) begin
            bundle_d  = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (dec_is_mul) begin
                            state_d = ST_MUL_BUSY;
                            cnt_d   = CNT_LOAD;
                        end else if (dec_is_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            illegal_d = 1'b1;
                            seen_d    = 1'b1;
`endif
                        end else if (!is_nop) begin
                            bundle_d = dec_bundle;
                            valid_d  = 1'b1;
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                        bundle_d = MUL_BUNDLE;
                        valid_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_LAST;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bundle_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bundle_q <= bundle_d;
            valid_q  <= valid_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            seen_q    <= seen_d;
        end
    end
`else
    assign illegal_q = 1'b0;
    assign seen_q    = 1'b0;
`endif

    assign out_valid    = valid_q;
    assign alu_command  = ALU_CMD_W'(bundle_q.alu_command);
    assign mem_read     = bundle_q.mem_read;
    assign mem_write    = bundle_q.mem_write;
    assign wb_enable    = bundle_q.wb_enable;
    assign is_immediate = bundle_q.is_immediate;
    assign branch       = bundle_q.branch;
    assign stall_o      = freeze | (state_q == ST_MUL_BUSY);
    assign illegal_o    = illegal_q;
    assign illegal_seen = seen_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: directed scenarios then random
// traffic, compared against a table-driven cycle model of the issue stage.
module tb_pipelined_control_unit;

    localparam int OPCODE_W   = 6;
    localparam int ALU_CMD_W  = 4;
    localparam int MUL_CYCLES = 4;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rstN;
    logic                 inValid;
    logic [OPCODE_W-1:0]  opcode;
    logic                 freeze;
    logic                 flush;
    logic                 outValid;
    logic [ALU_CMD_W-1:0] aluCommand;
    logic                 memRead, memWrite, wbEnable, isImmediate;
    logic [1:0]           branch;
    logic                 stallO, illegalO, illegalSeen;

    int checks   = 0;
    int failures = 0;

    // Reference model state: expected registered outputs and remaining MUL cycles.
    bit         mBusy;
    int         mLeft;
    logic       expValid, expRd, expWr, expWb, expImm, expIll, expSeen;
    logic [3:0] expCmd;
    logic [1:0] expBr;
    logic       lastStall;

    int regOps  [11] = '{1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 14};
    int regCmd  [11] = '{0, 2, 4, 5, 6, 7, 8, 8, 9, 10, 11};
    int validOps[19] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 14, 32, 33, 36, 37, 40, 41, 42};

    pipelined_control_unit #(
        .OPCODE_W   (OPCODE_W),
        .ALU_CMD_W  (ALU_CMD_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .in_valid     (inValid),
        .opcode       (opcode),
        .freeze       (freeze),
        .flush        (flush),
        .out_valid    (outValid),
        .alu_command  (aluCommand),
        .mem_read     (memRead),
        .mem_write    (memWrite),
        .wb_enable    (wbEnable),
        .is_immediate (isImmediate),
        .branch       (branch),
        .stall_o      (stallO),
        .illegal_o    (illegalO),
        .illegal_seen (illegalSeen)
    );

    always #5 clk = ~clk;

    function automatic bit refDecode(input int op, output logic [3:0] cmd,
                                     output logic rd, output logic wr,
                                     output logic wb, output logic imm,
                                     output logic [1:0] br);
        cmd = 4'd0; rd = 1'b0; wr = 1'b0; wb = 1'b0; imm = 1'b0; br = 2'b00;
        if (op == 0) return 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (regOps[i] == op) begin
                cmd = 4'(regCmd[i]);
                wb  = 1'b1;
                return 1'b1;
            end
        end
        if (op == 32 || op == 33) begin
            cmd = (op == 33) ? 4'd2 : 4'd0;
            wb  = 1'b1;
            imm = 1'b1;
            return 1'b1;
        end
        if (op == 36) begin rd = 1'b1; wb = 1'b1; imm = 1'b1; return 1'b1; end
        if (op == 37) begin wr = 1'b1; imm = 1'b1; return 1'b1; end
        if (op >= 40 && op <= 42) begin
            imm = 1'b1;
            br  = 2'(op - 39);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearExp();
        expValid = 1'b0; expCmd = 4'd0; expRd = 1'b0; expWr = 1'b0;
        expWb = 1'b0; expImm = 1'b0; expBr = 2'b00;
    endtask

    task automatic checkAll();
        checkOutput("out_valid",    32'(outValid),    32'(expValid));
        checkOutput("alu_command",  32'(aluCommand),  32'(expCmd));
        checkOutput("mem_read",     32'(memRead),     32'(expRd));
        checkOutput("mem_write",    32'(memWrite),    32'(expWr));
        checkOutput("wb_enable",    32'(wbEnable),    32'(expWb));
        checkOutput("is_immediate", 32'(isImmediate), 32'(expImm));
        checkOutput("branch",       32'(branch),      32'(expBr));
        checkOutput("illegal_o",    32'(illegalO),    32'(expIll));
        checkOutput("illegal_seen", 32'(illegalSeen), 32'(expSeen));
    endtask

    // One clock: drive at the falling edge, check stall before the rising edge,
    // advance the model at the edge, check registered outputs just after it.
    task automatic applyStimulus(input logic iv, input int op, input logic frz, input logic fl);
        logic [3:0] c;
        logic       r, w, b, im;
        logic [1:0] br;
        bit         defined;
        inValid = iv;
        opcode  = OPCODE_W'(op);
        freeze  = frz;
        flush   = fl;
        #1;
        lastStall = stallO;
        checkOutput("stall_o", 32'(stallO), 32'(frz | mBusy));
        @(posedge clk);
        if (fl) begin
            clearExp();
            mBusy  = 1'b0;
            mLeft  = 0;
            expIll = 1'b0;
        end else if (!frz) begin
            clearExp();
            expIll = 1'b0;
            if (mBusy) begin
                mLeft--;
                if (mLeft == 0) begin
                    mBusy    = 1'b0;
                    expValid = 1'b1;
                    expCmd   = 4'd11;
                    expWb    = 1'b1;
                end
            end else if (iv) begin
                if (op == 14) begin
                    mBusy = 1'b1;
                    mLeft = MUL_CYCLES - 1;
                end else begin
                    defined = refDecode(op, c, r, w, b, im, br);
                    if (!defined) begin
                        if (TRAP) begin
                            expIll  = 1'b1;
                            expSeen = 1'b1;
                        end
                    end else if (op != 0) begin
                        expValid = 1'b1; expCmd = c; expRd = r; expWr = w;
                        expWb = b; expImm = im; expBr = br;
                    end
                end
            end
        end
        #1;
        checkAll();
        @(negedge clk);
    endtask

    task automatic applyReset(input string tag);
        rstN = 1'b0;
        #1;
        checkOutput({tag, "_valid"},   32'(outValid),    32'd0);
        checkOutput({tag, "_cmd"},     32'(aluCommand),  32'd0);
        checkOutput({tag, "_ctrl"},    32'({memRead, memWrite, wbEnable, isImmediate}), 32'd0);
        checkOutput({tag, "_branch"},  32'(branch),      32'd0);
        checkOutput({tag, "_stall"},   32'(stallO),      32'd0);
        checkOutput({tag, "_illegal"}, 32'({illegalO, illegalSeen}), 32'd0);
        clearExp();
        mBusy = 1'b0; mLeft = 0; expIll = 1'b0; expSeen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        logic iv, frz, fl;
        int   op;
        inValid = 1'b0; opcode = '0; freeze = 1'b0; flush = 1'b0;
        applyReset("reset");

        $display("[TB] single ALU op");
        applyStimulus(1'b1, 1, 1'b0, 1'b0);
        checkOutput("add_valid", 32'(outValid), 32'd1);
        checkOutput("add_cmd",   32'(aluCommand), 32'd0);
        checkOutput("add_wb",    32'({wbEnable, isImmediate, branch}), 32'b1000);

        $display("[TB] LD then ST");
        applyStimulus(1'b1, 36, 1'b0, 1'b0);
        checkOutput("ld_ctrl", 32'({memRead, memWrite, wbEnable, isImmediate}), 32'b1011);
        applyStimulus(1'b1, 37, 1'b0, 1'b0);
        checkOutput("st_ctrl", 32'({memRead, memWrite, wbEnable, isImmediate}), 32'b0101);

        $display("[TB] MUL latency");
        applyStimulus(1'b1, 14, 1'b0, 1'b0);
        for (int i = 0; i < MUL_CYCLES - 1; i++) begin
            applyStimulus(1'b1, 1, 1'b0, 1'b0);
            checkOutput("mul_stall_hi", 32'(lastStall), 32'd1);
        end
        checkOutput("mul_issue", 32'({outValid, aluCommand, wbEnable}), 32'b1_1011_1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("mul_stall_lo", 32'(lastStall), 32'd0);

        $display("[TB] MUL with freeze");
        applyStimulus(1'b1, 14, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("mulfrz_wait", 32'(outValid), 32'd0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("mulfrz_issue", 32'({outValid, aluCommand}), 32'b1_1011);

        $display("[TB] MUL with flush");
        applyStimulus(1'b1, 14, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        checkOutput("mulfl_bubble", 32'(outValid), 32'd0);
        for (int i = 0; i < MUL_CYCLES; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b0);
            checkOutput("mulfl_noissue", 32'({lastStall, outValid}), 32'd0);
        end

        $display("[TB] flush beats MUL accept");
        applyStimulus(1'b1, 14, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("flmul_stall", 32'(lastStall), 32'd0);

        $display("[TB] undefined opcode");
        applyStimulus(1'b1, 63, 1'b0, 1'b0);
        checkOutput("ill_bubble", 32'(outValid), 32'd0);
        checkOutput("ill_pulse",  32'(illegalO), 32'(TRAP));
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("ill_pulse_end", 32'(illegalO), 32'd0);
        checkOutput("ill_sticky",    32'(illegalSeen), 32'(TRAP));

        $display("[TB] reset mid-MUL");
        applyStimulus(1'b1, 14, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        applyReset("rst_mul");
        for (int i = 0; i < MUL_CYCLES + 1; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b0);
            checkOutput("rst_mul_noissue", 32'({lastStall, outValid}), 32'd0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            op  = ($urandom_range(0, 9) < 7) ? validOps[$urandom_range(0, 18)]
                                             : int'($urandom_range(0, 63));
            iv  = ($urandom_range(0, 9) < 8);
            frz = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            applyStimulus(iv, op, frz, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
